fetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch controller for the single-cycle RISC-V core. It owns the architectural PC register and runs a request/grant/response handshake with instruction memory. It presents one fetched instruction at a time to decode, and applies redirects (the next-PC computed by the core's PC control logic for jumps and taken branches), discarding any fetch that is in flight when a redirect arrives.

---
 rtl/fetch_sequencer.sv | 96 +++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and imem request/grant/response fetch FSM with redirect handling.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc
);
`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DROP, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, DROP} state_t;
`endif
  state_t          r_state;
  state_t          w_go;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_ipc;
  logic            w_redir;
  logic [XLEN-1:0] w_rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;
  logic            w_mis;
  // once faulted, further redirects are ignored so fault_pc keeps the first offender
  assign w_redir     = redirect_valid & ~r_fault;
  assign w_mis       = w_redir & |redirect_pc[1:0];
  assign w_go        = (w_mis | r_fault) ? FAULT : REQ;
  assign w_rpc       = redirect_pc;
  assign fetch_fault = r_fault;
  assign fault_pc    = r_fault_pc;
`else
  assign w_redir     = redirect_valid;
  assign w_go        = REQ;
  assign w_rpc       = redirect_pc & ~XLEN'(3);
  assign fetch_fault = 1'b0;
  assign fault_pc    = '0;
`endif
  assign imem_req    = r_state == REQ;
  assign imem_addr   = imem_req ? r_pc : '0;
  assign instr_valid = r_state == HOLD;
  assign instr_out   = r_instr;
  assign instr_pc    = r_ipc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_ipc      <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
`endif
    end else begin
      if (w_redir) r_pc <= w_rpc;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_mis) begin
        r_fault    <= 1'b1;
        r_fault_pc <= redirect_pc;
      end
`endif
      case (r_state)
        IDLE: r_state <= w_redir ? w_go : (halt ? IDLE : REQ);
        REQ:  r_state <= w_redir ? (imem_gnt ? DROP : w_go) : (imem_gnt ? RESP : REQ);
        RESP: begin
          r_state <= w_redir ? (imem_rvalid ? w_go : DROP) : (imem_rvalid ? HOLD : RESP);
          if (!w_redir && imem_rvalid) begin
            r_instr <= imem_rdata;
            r_ipc   <= r_pc;
          end
        end
        HOLD: begin
          r_state <= w_redir ? w_go : (instr_ready ? (halt ? IDLE : REQ) : HOLD);
          if (!w_redir && instr_ready) r_pc <= r_pc + XLEN'(4);
        end
        DROP: if (imem_rvalid) r_state <= w_go;
        default: r_state <= r_state;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench; expected instruction stream from a PC-sequence model.
module tb_fetch_sequencer;
  logic clk = 0, rst_n = 0, halt = 0, imem_gnt = 0, imem_rvalid = 0, instr_ready = 0, redirect_valid = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, instr_valid, fetch_fault;
  logic [31:0] imem_addr, instr_out, instr_pc, fault_pc;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fault_pc(fault_pc)
  );

  int vecs = 0, errs = 0, pops = 0;
  logic [31:0] sbq[$];
  logic [31:0] mq[$];
  logic [31:0] exp_pc, cur_pc;
  bit need_pop, faulted, f_redir;
  logic [31:0] f_pc;
  int gnt_pct, rv_pct, rdy_pct, redir_pct, halt_pct;
  logic s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_out, s_ipc, s_fpc;
  logic [31:0] addrs[3];
  int vc[4];
  int na, nv;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    mq.delete();
    exp_pc = 32'h100;
    sbq.push_back(exp_pc);
    need_pop = 1;
    faulted = 0;
  endtask

  // One cycle: snapshot outputs, act as memory and decode, advance the PC-sequence model.
  task automatic step();
    @(negedge clk);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_out = instr_out; s_ipc = instr_pc; s_fault = fetch_fault; s_fpc = fault_pc;
    imem_rvalid = 0;
    imem_rdata = $urandom;
    if (mq.size() != 0 && pct(rv_pct)) begin
      imem_rvalid = 1;
      imem_rdata = mem(mq.pop_front());
    end
    imem_gnt = pct(gnt_pct);
    if (s_req && imem_gnt) mq.push_back(s_addr);
    redirect_valid = f_redir || pct(redir_pct);
    redirect_pc = f_redir ? f_pc : 32'h1000 + ($urandom_range(0, 255) << 2);
    f_redir = 0;
    instr_ready = pct(rdy_pct);
    halt = pct(halt_pct);
    if (!faulted) begin
      if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redirect_pc[1:0] != 2'b00) begin
          faulted = 1;
          sbq.delete();
        end else
`endif
        begin
          exp_pc = redirect_pc & ~32'h3;
          sbq.delete();
          sbq.push_back(exp_pc);
        end
        if (s_valid) need_pop = 1;
      end else if (s_valid && instr_ready) begin
        exp_pc = exp_pc + 32'd4;
        sbq.push_back(exp_pc);
        need_pop = 1;
      end
    end
  endtask

  task automatic wait_valid(input string n);
    int k = 0;
    do begin step(); k++; end while (!s_valid && k < 200);
    if (!s_valid) begin
      vecs++; errs++;
      $display("FAIL %s: got no instr_valid expected instr_valid within 200 cycles", n);
    end
  endtask

  task automatic wait_req(input string n, input logic [31:0] a);
    int k = 0;
    do begin step(); k++; end while (!s_req && k < 200);
    if (!s_req) begin
      vecs++; errs++;
      $display("FAIL %s: got no imem_req expected imem_req addr %h", n, a);
    end else chk(n, s_addr, a);
  endtask

  task automatic wait_resp(input string n);
    int k = 0;
    do begin step(); k++; end while (!(!s_req && !s_valid && mq.size() == 1) && k < 200);
    if (!(!s_req && !s_valid && mq.size() == 1)) begin
      vecs++; errs++;
      $display("FAIL %s: got no outstanding fetch expected one within 200 cycles", n);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_req"}, imem_req, 0);
    chk({n, "_addr"}, imem_addr, 0);
    chk({n, "_valid"}, instr_valid, 0);
    chk({n, "_out"}, instr_out, 0);
    chk({n, "_ipc"}, instr_pc, 0);
    chk({n, "_fault"}, fetch_fault, 0);
    chk({n, "_fpc"}, fault_pc, 0);
  endtask

  // Monitor: pops one expectation per new presentation and checks it every cycle it is held.
  always @(negedge clk) begin
    if (rst_n && instr_valid) begin
      if (need_pop) begin
        if (sbq.size() == 0) begin
          vecs++; errs++;
          $display("FAIL sb_empty: got presentation pc %h expected none", instr_pc);
        end else cur_pc = sbq.pop_front();
        need_pop = 0;
        pops++;
      end
      chk("instr_pc", instr_pc, cur_pc);
      chk("instr_out", instr_out, mem(cur_pc));
      chk("req_in_hold", imem_req, 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100; redir_pct = 0; halt_pct = 0; f_redir = 0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    na = 0; nv = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) chk("first_req", s_req, 1);
      if (s_req && na < 3) begin addrs[na] = s_addr; na++; end
      if (s_valid && nv < 4) begin vc[nv] = i; nv++; end
    end
    chk("seq_addr0", addrs[0], 32'h100);
    chk("seq_addr1", addrs[1], 32'h104);
    chk("seq_addr2", addrs[2], 32'h108);
    chk("seq_valid_count", nv, 3);
    chk("seq_spacing", vc[1] - vc[0], 3);
    rv_pct = 0;
    wait_resp("resp_wait");
    f_redir = 1; f_pc = 32'h200;
    step();
    rv_pct = 100;
    wait_req("redir_resp_addr", 32'h200);
    rdy_pct = 0;
    wait_valid("hold_wait");
    f_redir = 1; f_pc = 32'h300; rdy_pct = 100;
    step();
    wait_req("redir_hold_addr", 32'h300);
    rdy_pct = 0;
    wait_valid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", s_valid, 1);
      chk("stall_pc", s_ipc, 32'h300);
      chk("stall_out", s_out, mem(32'h300));
      chk("stall_req", s_req, 0);
    end
    halt_pct = 100; rdy_pct = 100;
    step();
    rdy_pct = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", s_req, 0);
    end
    halt_pct = 0;
    wait_req("halt_release", 32'h304);
    wait_valid("wrap_pre_hold");
    f_redir = 1; f_pc = 32'hFFFF_FFFC;
    step();
    wait_req("wrap_pre", 32'hFFFF_FFFC);
    wait_valid("wrap_hold");
    rdy_pct = 100;
    wait_req("wrap_addr", 32'h0);
    rv_pct = 0;
    wait_resp("rst_resp_wait");
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1;
    rv_pct = 100;
    wait_req("rst_refetch", 32'h100);
    gnt_pct = 60; rv_pct = 50; rdy_pct = 70; redir_pct = 8; halt_pct = 15;
    repeat (3000) step();
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100; redir_pct = 0; halt_pct = 0;
    repeat (20) step();
    chk("progress", pops > 100, 1);
    rdy_pct = 0;
    wait_valid("mis_wait");
    f_redir = 1; f_pc = 32'h202;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    step();
    chk("fault_flag", s_fault, 1);
    chk("fault_pc", s_fpc, 32'h202);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("fault_req", s_req, 0);
      chk("fault_valid", s_valid, 0);
      chk("fault_sticky", s_fault, 1);
    end
    @(negedge clk);
    #1 rst_n = 0;
    #1 chk_zero("fault_rst");
    model_reset();
    @(negedge clk);
    #1 rst_n = 1;
    wait_req("fault_refetch", 32'h100);
`else
    wait_req("mis_addr", 32'h200);
    chk("nofault_flag", s_fault, 0);
    chk("nofault_pc", s_fpc, 0);
    rdy_pct = 100;
    wait_valid("mis_present");
`endif
    repeat (5) step();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
